// File: rtl/mdu_if.sv
// mdu_if: E-stage multiply/divide request, stall and HI/LO result signals
interface mdu_if;
  logic [3:0]  E_md_op;
  logic [31:0] E_rs_m;
  logic [31:0] E_rt_m;
  logic        D_is_md;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rd;
  modport slave (input E_md_op, E_rs_m, E_rt_m, D_is_md, output start, busy, md_stall, hi, lo, md_rd);
  modport master (output E_md_op, E_rs_m, E_rt_m, D_is_md, input start, busy, md_stall, hi, lo, md_rd);
endinterface

// File: rtl/mdu_scheduler.sv
// mdu_scheduler: HI/LO owner for the E stage; computes results at start and holds them
// back for a fixed latency so the pipeline sees realistic mult/div timing.
module mdu_scheduler #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave m
);
  logic [3:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_phi, r_plo;
  logic        w_mul, w_div, w_start, w_rt_zero;
  logic [63:0] w_sprod, w_uprod, w_pend;
  logic [31:0] w_ubs, w_uq, w_ur, w_sa, w_sb, w_sbs, w_mq, w_mr, w_sq, w_sr;
  assign w_mul     = m.E_md_op == 4'd1 || m.E_md_op == 4'd2;
  assign w_div     = m.E_md_op == 4'd3 || m.E_md_op == 4'd4;
  assign w_start   = (w_mul || w_div) && r_cnt == 4'd0;
  assign w_rt_zero = m.E_rt_m == 32'd0;
  assign w_sprod   = {{32{m.E_rs_m[31]}}, m.E_rs_m} * {{32{m.E_rt_m[31]}}, m.E_rt_m};
  assign w_uprod   = {32'd0, m.E_rs_m} * {32'd0, m.E_rt_m};
  assign w_ubs     = w_rt_zero ? 32'd1 : m.E_rt_m;
  assign w_uq      = m.E_rs_m / w_ubs;
  assign w_ur      = m.E_rs_m % w_ubs;
  // signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow
  assign w_sa      = m.E_rs_m[31] ? -m.E_rs_m : m.E_rs_m;
  assign w_sb      = m.E_rt_m[31] ? -m.E_rt_m : m.E_rt_m;
  assign w_sbs     = w_rt_zero ? 32'd1 : w_sb;
  assign w_mq      = w_sa / w_sbs;
  assign w_mr      = w_sa % w_sbs;
  assign w_sq      = (m.E_rs_m[31] ^ m.E_rt_m[31]) ? -w_mq : w_mq;
  assign w_sr      = m.E_rs_m[31] ? -w_mr : w_mr;
  assign w_pend    = m.E_md_op == 4'd1 ? w_sprod :
                     m.E_md_op == 4'd2 ? w_uprod :
                     w_rt_zero         ? {r_hi, r_lo} :
                     m.E_md_op == 4'd3 ? {w_sr, w_sq} : {w_ur, w_uq};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 4'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_phi <= 32'd0;
      r_plo <= 32'd0;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
    end else if (w_start) begin
      r_cnt          <= w_mul ? 4'(MUL_LAT) : 4'(DIV_LAT);
      {r_phi, r_plo} <= w_pend;
    end else begin
      if (m.E_md_op == 4'd7) r_hi <= m.E_rs_m;
      if (m.E_md_op == 4'd8) r_lo <= m.E_rs_m;
    end
  end
  assign m.start    = w_start;
  assign m.busy     = r_cnt != 4'd0;
  assign m.md_stall = m.D_is_md & (m.busy | w_start);
  assign m.hi       = r_hi;
  assign m.lo       = r_lo;
  assign m.md_rd    = m.E_md_op == 4'd5 ? r_hi : m.E_md_op == 4'd6 ? r_lo : 32'd0;
endmodule

// File: tb/tb_mdu_scheduler.sv
// tb_mdu_scheduler: random + directed stimulus, completion scoreboard fed by an
// arithmetic reference model of HI/LO.
module tb_mdu_scheduler;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  logic clk = 1'b0;
  logic reset;
  logic rst_q = 1'b0;
  logic prev_busy = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int viol = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] m_hi, m_lo;
  always #5 clk = ~clk;
  mdu_if bus();
  mdu_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (.clk(clk), .reset(reset), .m(bus));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] cur);
    longint sa = $signed(a);
    longint sb = $signed(b);
    case (op)
      4'd1: return sa * sb;
      4'd2: return {32'd0, a} * {32'd0, b};
      4'd3: if (b == 32'd0) return cur; else return {32'(sa % sb), 32'(sa / sb)};
      4'd4: if (b == 32'd0) return cur; else return {a % b, a / b};
      default: return cur;
    endcase
  endfunction
  // protocol watch: any md-class op reaching E while a multi-cycle op is in flight
  always @(posedge clk) begin
    rst_q <= reset;
    if (!reset && bus.busy && bus.E_md_op >= 4'd1 && bus.E_md_op <= 4'd8) viol <= viol + 1;
  end
  always @(negedge clk) begin
    if (prev_busy && !bus.busy && !rst_q) begin
      if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("hilo_done", {bus.hi, bus.lo}, mon_e);
      end
    end
    prev_busy = bus.busy;
  end
  task automatic do_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit d, input bit force_mt);
    int n = 0;
    int v0;
    int lat = (op <= 4'd2) ? MUL_LAT : DIV_LAT;
    logic [31:0] lo_before = 32'd0;
    bus.E_md_op = op;
    bus.E_rs_m  = a;
    bus.E_rt_m  = b;
    bus.D_is_md = d;
    @(negedge clk);
    chk("start", 64'(bus.start), 64'd1);
    chk("stall_start", 64'(bus.md_stall), 64'(d));
    exp_q.push_back(model(op, a, b, {m_hi, m_lo}));
    {m_hi, m_lo} = exp_q[$];
    v0 = viol;
    @(posedge clk);
    #1 bus.E_md_op = 4'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      chk("stall_busy", 64'(bus.md_stall), 64'(d));
      if (force_mt && i == 1) begin
        lo_before   = bus.lo;
        bus.E_md_op = 4'd8;
        bus.E_rs_m  = ~bus.lo;
      end
      if (force_mt && i == 2) begin
        chk("mtlo_ignored", 64'(bus.lo), 64'(lo_before));
        bus.E_md_op = 4'd1;
        #1 chk("no_start_busy", 64'(bus.start), 64'd0);
      end
      if (force_mt && i == 3) bus.E_md_op = 4'd0;
    end
    chk("busy_len", 64'(n), 64'(lat));
    chk("stall_after", 64'(bus.md_stall), 64'd0);
    if (force_mt) chk("violations", 64'(viol - v0), 64'd2);
    @(posedge clk);
    #1;
  endtask
  task automatic do_mf(input logic [3:0] op, input bit d);
    bus.E_md_op = op;
    bus.D_is_md = d;
    @(negedge clk);
    chk("md_rd", 64'(bus.md_rd), 64'(op == 4'd5 ? m_hi : m_lo));
    chk("mf_nostall", 64'(bus.md_stall), 64'd0);
    @(posedge clk);
    #1 bus.E_md_op = 4'd0;
  endtask
  task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
    bus.E_md_op = op;
    bus.E_rs_m  = a;
    bus.D_is_md = 1'b0;
    @(negedge clk);
    chk("mt_rd_zero", 64'(bus.md_rd), 64'd0);
    @(posedge clk);
    #1 bus.E_md_op = 4'd0;
    if (op == 4'd7) m_hi = a; else m_lo = a;
    @(negedge clk);
    chk("mt_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    @(posedge clk);
    #1;
  endtask
  task automatic do_idle(input logic [3:0] op);
    bus.E_md_op = op;
    bus.D_is_md = 1'b1;
    @(negedge clk);
    chk("idle_start", 64'(bus.start), 64'd0);
    chk("idle_stall", 64'(bus.md_stall), 64'd0);
    chk("idle_rd", 64'(bus.md_rd), 64'd0);
    @(posedge clk);
    #1 bus.E_md_op = 4'd0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [3:0] op;
    logic [31:0] a, b;
    reset = 1'b1;
    bus.E_md_op = 4'd0;
    bus.E_rs_m  = 32'd0;
    bus.E_rt_m  = 32'd0;
    bus.D_is_md = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_start", 64'(bus.start), 64'd0);
    @(posedge clk);
    #1;
    do_md(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    chk("mult_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFA);
    do_md(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    chk("multu_const", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    do_md(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    chk("div_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_md(4'd4, 32'd7, 32'd0, 1'b1, 1'b0);
    chk("divu_zero", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_md(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("div_ovf", {bus.hi, bus.lo}, 64'h00000000_80000000);
    do_md(4'd1, 32'd1234, 32'd5678, 1'b1, 1'b0);
    do_mf(4'd6, 1'b1);
    do_mt(4'd7, 32'h12345678);
    chk("mthi_const", 64'(bus.hi), 64'h12345678);
    do_md(4'd1, $urandom, $urandom, 1'b1, 1'b1);
    do_mt(4'd7, 32'hCAFEF00D);
    do_mt(4'd8, 32'h0BADBEEF);
    bus.E_md_op = 4'd3;
    bus.E_rs_m  = 32'd1000;
    bus.E_rt_m  = 32'd7;
    @(posedge clk);
    #1 bus.E_md_op = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 64'(bus.busy), 64'd0);
    chk("rstmid_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (12) @(negedge clk);
    chk("rstmid_late", {bus.hi, bus.lo}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ((op == 4'd3 || op == 4'd4) && $urandom_range(0, 3) == 0) b = 32'd0;
      if (op >= 4'd1 && op <= 4'd4) do_md(op, a, b, 1'($urandom_range(0, 1)), 1'b0);
      else if (op == 4'd5 || op == 4'd6) do_mf(op, 1'($urandom_range(0, 1)));
      else if (op == 4'd7 || op == 4'd8) do_mt(op, a);
      else do_idle(op);
    end
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
